swt_egress_arbiter: RTL and testbench

- Shares one 32-bit egress bus (port/sop/eop framing) of the simple switch between NUM_IN ingress requesters.
- Arbitrates per packet, round robin: a grant is held from the sop beat through the eop beat.
- Output is registered and backpressured by out_ready.
- A watchdog closes packets whose source stalls mid-packet.

---
 rtl/swt_egress_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_swt_egress_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swt_egress_arbiter.sv
// swt_egress_arbiter
//   Shares one egress port bus (data + sop/eop framing) between NUM_IN
//   ingress requesters. Arbitration is round robin and per packet: once a
//   requester wins, it owns the bus from its sop beat through its eop beat.
//   The egress word is registered and backpressured by out_ready. A
//   watchdog closes a packet whose source stalls mid-packet by emitting a
//   zero-data eop beat.
//
// Ports
//   clk, reset    : clock; synchronous active-high reset
//   in_port       : NUM_IN packed ingress words, requester i at [i*DATA_W +: DATA_W]
//   in_valid/sop/eop : per-requester word present / first / last
//   in_ready      : per-requester word accepted (with in_valid)
//   out_port/valid/sop/eop : registered egress beat
//   out_ready     : downstream accepts the egress beat
//   grant_id      : current or last granted requester
//   busy          : a packet transfer is in progress
//   timeout_err   : one-cycle pulse when the watchdog closes a packet
//   drop_err      : one-cycle pulse when a non-sop word is discarded while idle
//   pkt_count     : packets completed by a real eop beat (wraps)
module swt_egress_arbiter #(
    parameter int NUM_IN  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN*DATA_W-1:0] in_port,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN-1:0]        in_sop,
    input  logic [NUM_IN-1:0]        in_eop,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_port,
    output logic                     out_valid,
    output logic                     out_sop,
    output logic                     out_eop,
    input  logic                     out_ready,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     drop_err,
    output logic [15:0]              pkt_count
);

    // Watchdog wide enough to hold TIMEOUT itself.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_last_q, rr_last_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [DATA_W-1:0]   out_port_q, out_port_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sop_q, out_sop_d;
    logic                out_eop_q, out_eop_d;
    logic                timeout_err_q, timeout_err_d;
    logic                drop_err_q, drop_err_d;
    logic [15:0]         pkt_count_q, pkt_count_d;

    logic [NUM_IN-1:0]   in_ready_c;
    logic                adv;
    logic                found;
    logic [ID_W-1:0]     winner;
    logic [ID_W-1:0]     cand;
    logic [DATA_W-1:0]   words [NUM_IN];

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
        assign words[gi] = in_port[gi*DATA_W +: DATA_W];
    end

    // Output register may load when it is empty or being drained.
    assign adv = out_ready | ~out_valid_q;

    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        grant_d       = grant_q;
        wd_d          = wd_q;
        out_port_d    = out_port_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_valid_d   = adv ? 1'b0 : out_valid_q;
        timeout_err_d = 1'b0;
        drop_err_d    = 1'b0;
        pkt_count_d   = pkt_count_q;
        in_ready_c    = '0;
        found         = 1'b0;
        winner        = '0;
        cand          = '0;

        case (state_q)
            IDLE: begin
                wd_d = '0;
                // Stray mid-packet words are swallowed so they cannot block.
                in_ready_c = in_valid & ~in_sop;
                drop_err_d = |(in_valid & ~in_sop);
                // Search starts just after the last winner, wrapping around.
                for (int unsigned k = 1; k <= NUM_IN; k++) begin
                    cand = ID_W'((32'(rr_last_q) + k) % NUM_IN);
                    if (!found && in_valid[cand] && in_sop[cand]) begin
                        found  = 1'b1;
                        winner = cand;
                    end
                end
                if (found) begin
                    grant_d   = winner;
                    rr_last_d = winner;
                    state_d   = XFER;
                end
            end

            XFER: begin
                in_ready_c[grant_q] = adv;
                if (adv && in_valid[grant_q]) begin
                    out_port_d  = words[grant_q];
                    out_sop_d   = in_sop[grant_q];
                    out_eop_d   = in_eop[grant_q];
                    out_valid_d = 1'b1;
                    wd_d        = '0;
                    if (in_eop[grant_q]) begin
                        state_d     = IDLE;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end else if (adv && (TIMEOUT != 0) && (wd_q == WD_MAX)) begin
                    // Synthesised closing beat for a stalled source.
                    out_port_d    = '0;
                    out_sop_d     = 1'b0;
                    out_eop_d     = 1'b1;
                    out_valid_d   = 1'b1;
                    timeout_err_d = 1'b1;
                    wd_d          = '0;
                    state_d       = IDLE;
                end else if (adv && (TIMEOUT != 0)) begin
                    // Only source starvation counts; backpressure holds the count.
                    wd_d = wd_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_last_q     <= ID_W'(NUM_IN - 1);
            grant_q       <= '0;
            wd_q          <= '0;
            out_port_q    <= '0;
            out_valid_q   <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            drop_err_q    <= 1'b0;
            pkt_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            grant_q       <= grant_d;
            wd_q          <= wd_d;
            out_port_q    <= out_port_d;
            out_valid_q   <= out_valid_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            timeout_err_q <= timeout_err_d;
            drop_err_q    <= drop_err_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    assign in_ready    = reset ? '0 : in_ready_c;
    assign out_port    = out_port_q;
    assign out_valid   = out_valid_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q == XFER);
    assign timeout_err = timeout_err_q;
    assign drop_err    = drop_err_q;
    assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_swt_egress_arbiter.sv
module tb_swt_egress_arbiter;

    localparam int NI = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NI*DW-1:0]  in_port = '0;
    logic [NI-1:0]     in_valid = '0;
    logic [NI-1:0]     in_sop = '0;
    logic [NI-1:0]     in_eop = '0;
    logic [NI-1:0]     in_ready;
    logic [DW-1:0]     out_port;
    logic              out_valid, out_sop, out_eop;
    logic              out_ready = 1'b1;
    logic [1:0]        grant_id;
    logic              busy, timeout_err, drop_err;
    logic [15:0]       pkt_count;

    swt_egress_arbiter #(.NUM_IN(NI), .DATA_W(DW), .TIMEOUT(TO), .ID_W(2)) dut (
        .clk(clk), .reset(reset), .in_port(in_port), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
        .out_port(out_port), .out_valid(out_valid), .out_sop(out_sop),
        .out_eop(out_eop), .out_ready(out_ready), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err), .drop_err(drop_err),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet-level rules, integer state)
    bit          m_busy, m_ov, m_os, m_oe, m_terr, m_derr;
    int          m_owner, m_last, m_stall, m_cnt;
    logic [31:0] m_port;

    always @(posedge clk) begin : model
        bit adv;
        int c;
        if (reset) begin
            m_busy = 0; m_ov = 0; m_os = 0; m_oe = 0; m_terr = 0; m_derr = 0;
            m_owner = 0; m_last = NI - 1; m_stall = 0; m_cnt = 0; m_port = 0;
        end else begin
            adv = out_ready || !m_ov;
            m_terr = 0;
            m_derr = 0;
            if (!m_busy) begin
                if ((in_valid & ~in_sop) != 0) m_derr = 1;
                if (adv) m_ov = 0;
                for (int k = 1; k <= NI; k++) begin
                    c = (m_last + k) % NI;
                    if (in_valid[c] && in_sop[c]) begin
                        m_owner = c; m_last = c; m_busy = 1; m_stall = 0;
                        break;
                    end
                end
            end else if (adv && in_valid[m_owner]) begin
                m_port = in_port[m_owner*DW +: DW];
                m_ov = 1; m_os = in_sop[m_owner]; m_oe = in_eop[m_owner];
                m_stall = 0;
                if (m_oe) begin
                    m_busy = 0;
                    m_cnt = (m_cnt + 1) % 65536;
                end
            end else if (adv && m_stall >= TO) begin
                m_port = 0; m_ov = 1; m_os = 0; m_oe = 1;
                m_terr = 1; m_busy = 0; m_stall = 0;
            end else if (adv) begin
                m_ov = 0;
                m_stall++;
            end
        end
    end

    // ---------------- per-cycle compare, plus log of accepted egress beats
    logic [33:0] eg_log[$];

    always @(negedge clk) begin : compare
        logic [NI-1:0] er;
        bit adv;
        if (chk_en) begin
            adv = out_ready || !m_ov;
            if (reset) er = '0;
            else if (m_busy) er = adv ? (NI'(1) << m_owner) : '0;
            else er = in_valid & ~in_sop;
            check("in_ready", in_ready, er);
            check("out_valid", out_valid, m_ov);
            check("out_port", out_port, m_port);
            check("out_sop", out_sop, m_os);
            check("out_eop", out_eop, m_oe);
            check("grant_id", grant_id, m_owner);
            check("busy", busy, m_busy);
            check("timeout_err", timeout_err, m_terr);
            check("drop_err", drop_err, m_derr);
            check("pkt_count", pkt_count, m_cnt);
            if (out_valid && out_ready) eg_log.push_back({out_sop, out_eop, out_port});
        end
    end

    // ---------------- sources
    typedef struct packed {logic sop; logic eop; logic [31:0] data;} beat_t;
    beat_t srcq[NI][$];
    int    hold[NI];

    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            if (hold[i] == 0 && srcq[i].size() > 0) begin
                in_valid[i] = 1'b1;
                in_sop[i]   = srcq[i][0].sop;
                in_eop[i]   = srcq[i][0].eop;
                in_port[i*DW +: DW] = srcq[i][0].data;
            end else begin
                in_valid[i] = 1'b0;
                in_sop[i]   = 1'b0;
                in_eop[i]   = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [NI-1:0] acc;
        @(negedge clk);
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            if (hold[i] > 0) hold[i]--;
        end
        drive();
    endtask

    task automatic clear_src();
        for (int i = 0; i < NI; i++) begin
            srcq[i].delete();
            hold[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_ready = 1'b1;
        clear_src();
        drive();
        step();
        chk_en = 1;
        step();
        reset = 1'b0;
        eg_log.delete();
    endtask

    task automatic push_pkt(input int r, input int len, input logic [31:0] base);
        for (int j = 0; j < len; j++)
            srcq[r].push_back('{sop: (j == 0), eop: (j == len - 1), data: base + 32'(j)});
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin : main
        logic [NI-1:0] bpat;
        int grants[$];
        bit prev;
        int nterr;
        logic [9:0] busy_pat;

        for (int i = 0; i < NI; i++) hold[i] = 0;

        // reset state
        do_reset();
        check("rst_out_port", out_port, 32'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_grant", grant_id, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_pkt", pkt_count, 16'd0);
        check("rst_in_ready", in_ready, 4'b0000);

        // single 3-word packet from requester 2
        push_pkt(2, 3, 32'hA0);
        drive();
        step();
        check("t1_grant", grant_id, 2'd2);
        check("t1_busy", busy, 1'b1);
        step();
        check("t1_w0", {out_valid, out_sop, out_eop, out_port}, {3'b110, 32'hA0});
        step();
        check("t1_w1", {out_valid, out_sop, out_eop, out_port}, {3'b100, 32'hA1});
        step();
        check("t1_w2", {out_valid, out_sop, out_eop, out_port}, {3'b101, 32'hA2});
        check("t1_pkt", pkt_count, 16'd1);
        check("t1_model_pkt", 64'(m_cnt), 64'd1);

        // four simultaneous streams of single-beat packets
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NI; i++) push_pkt(i, 1, 32'h100 + 32'(16 * r + i));
        drive();
        prev = 0;
        busy_pat = '0;
        for (int c = 0; c < 18; c++) begin
            step();
            if (c < 10) busy_pat[9 - c] = busy;
            if (busy && !prev) grants.push_back(int'(grant_id));
            prev = busy;
        end
        check("t2_bubbles", busy_pat, 10'b1010101010);
        check("t2_ngrants", grants.size(), 8);
        if (grants.size() >= 5) begin
            check("t2_g0", grants[0], 0);
            check("t2_g1", grants[1], 1);
            check("t2_g2", grants[2], 2);
            check("t2_g3", grants[3], 3);
            check("t2_g4", grants[4], 0);
        end
        check("t2_pkt", pkt_count, 16'd8);

        // downstream backpressure mid-packet
        do_reset();
        push_pkt(1, 4, 32'hB0);
        drive();
        repeat (3) step();
        out_ready = 1'b0;
        nterr = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (timeout_err) nterr++;
            if (c == 9) begin
                check("t3_hold_port", out_port, 32'hB1);
                check("t3_hold_ready", in_ready[1], 1'b0);
            end
        end
        check("t3_no_terr", nterr, 0);
        out_ready = 1'b1;
        repeat (5) step();
        check("t3_nbeats", eg_log.size(), 4);
        if (eg_log.size() == 4) begin
            check("t3_b0", eg_log[0], {2'b10, 32'hB0});
            check("t3_b1", eg_log[1], {2'b00, 32'hB1});
            check("t3_b2", eg_log[2], {2'b00, 32'hB2});
            check("t3_b3", eg_log[3], {2'b01, 32'hB3});
        end

        // watchdog close
        do_reset();
        srcq[0].push_back('{sop: 1'b1, eop: 1'b0, data: 32'hC0});
        drive();
        nterr = 0;
        for (int c = 0; c < 14; c++) begin
            step();
            if (timeout_err) nterr++;
        end
        check("t4_terr_once", nterr, 1);
        check("t4_nbeats", eg_log.size(), 2);
        if (eg_log.size() == 2) begin
            check("t4_sop_beat", eg_log[0], {2'b10, 32'hC0});
            check("t4_close_beat", eg_log[1], {2'b01, 32'h0});
        end
        check("t4_pkt", pkt_count, 16'd0);
        check("t4_idle", busy, 1'b0);

        // stray word while idle
        do_reset();
        srcq[3].push_back('{sop: 1'b0, eop: 1'b0, data: 32'hD0});
        drive();
        #1;
        bpat = in_ready;
        check("t5_ready", bpat, 4'b1000);
        step();
        check("t5_drop", drop_err, 1'b1);
        check("t5_no_grant", busy, 1'b0);
        check("t5_consumed", in_valid[3], 1'b0);
        step();
        check("t5_drop_pulse", drop_err, 1'b0);

        // reset mid-transfer, then fresh contention
        do_reset();
        push_pkt(2, 4, 32'hE0);
        drive();
        repeat (3) step();
        reset = 1'b1;
        clear_src();
        drive();
        step();
        check("t6_outs", {out_valid, out_sop, out_eop, out_port}, 35'h0);
        check("t6_busy", busy, 1'b0);
        check("t6_flags", {timeout_err, drop_err, grant_id}, 4'h0);
        reset = 1'b0;
        push_pkt(0, 1, 32'hF0);
        push_pkt(3, 1, 32'hF3);
        drive();
        step();
        check("t6_first", grant_id, 2'd0);
        repeat (2) step();
        check("t6_second", grant_id, 2'd3);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            out_ready = ($urandom % 4) != 0;
            for (int i = 0; i < NI; i++) begin
                if (srcq[i].size() < 3 && ($urandom % 5) == 0) begin
                    if (($urandom % 20) == 0)
                        srcq[i].push_back('{sop: 1'b0, eop: 1'($urandom % 2), data: $urandom});
                    else
                        push_pkt(i, 1 + int'($urandom % 4), $urandom);
                end
                if (hold[i] == 0 && ($urandom % 25) == 0)
                    hold[i] = (($urandom % 3) == 0) ? 10 + int'($urandom % 4) : 1 + int'($urandom % 2);
            end
            drive();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
